// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-granular arbiter sharing one UART transmitter between
// NUM_REQ byte-stream requesters; an owner keeps the grant until its last byte or a timeout.
module uart_tx_arbiter #(
    parameter int DATA_BITS      = 8,
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int TIMEOUT_BITS   = 20
) (
    input  logic                           clk_50MHz,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
    input  logic [NUM_REQ-1:0]             req_last,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           tx_start,
    output logic [DATA_BITS-1:0]           tx_data,
    input  logic                           tx_busy,
    input  logic                           tx_done_tick,
    output logic [NUM_REQ-1:0]             grant,
    output logic                           active,
    output logic                           timeout_evt
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(NUM_REQ - 1);
    localparam logic [TIMEOUT_BITS-1:0] TMO_LAST = TIMEOUT_BITS'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    // First requesting index after 'last', wrapping modulo NUM_REQ.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                                 input logic [IDX_W-1:0]   last);
        logic [IDX_W-1:0] pick;
        logic             found;
        logic             hit;
        int               idx;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx   = int'(last) + k;
            idx   = (idx >= NUM_REQ) ? (idx - NUM_REQ) : idx;
            hit   = !found && valid[idx];
            pick  = hit ? IDX_W'(idx) : pick;
            found = found | hit;
        end
        return pick;
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        return NUM_REQ'(1) << idx;
    endfunction

    state_t                  state_r, state_s;
    logic [NUM_REQ-1:0]      grant_r, grant_s;
    logic                    active_r, active_s;
    logic [NUM_REQ-1:0]      req_ready_r, req_ready_s;
    logic                    tx_start_r, tx_start_s;
    logic [DATA_BITS-1:0]    tx_data_r, tx_data_s;
    logic                    timeout_evt_r, timeout_evt_s;
    logic [IDX_W-1:0]        last_grant_r, last_grant_s;
    logic [IDX_W-1:0]        owner_r, owner_s;
    logic                    last_flag_r, last_flag_s;
    logic [TIMEOUT_BITS-1:0] cnt_r, cnt_s;

    logic [IDX_W-1:0]        pick_s;
    logic                    owner_valid_s;
    logic                    owner_last_s;
    logic [DATA_BITS-1:0]    owner_data_s;

    assign pick_s        = rr_pick(req_valid, last_grant_r);
    assign owner_valid_s = req_valid[owner_r];
    assign owner_last_s  = req_last[owner_r];
    assign owner_data_s  = req_data[int'(owner_r)*DATA_BITS +: DATA_BITS];

    // Next-state and next-output decode; pulses default low every cycle.
    always_comb begin
        state_s       = state_r;
        grant_s       = grant_r;
        active_s      = active_r;
        req_ready_s   = '0;
        tx_start_s    = 1'b0;
        tx_data_s     = tx_data_r;
        timeout_evt_s = 1'b0;
        last_grant_s  = last_grant_r;
        owner_s       = owner_r;
        last_flag_s   = last_flag_r;
        cnt_s         = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (|req_valid) begin
                    owner_s  = pick_s;
                    grant_s  = onehot(pick_s);
                    active_s = 1'b1;
                    cnt_s    = '0;
                    state_s  = ST_SEND;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (owner_valid_s && !tx_busy) begin
                    tx_data_s   = owner_data_s;
                    tx_start_s  = 1'b1;
                    req_ready_s = onehot(owner_r);
                    last_flag_s = owner_last_s;
                    cnt_s       = '0;
                    state_s     = ST_WAIT;
                end else if (owner_valid_s) begin
                    cnt_s = '0;
                end else if (cnt_r == TMO_LAST) begin
                    timeout_evt_s = 1'b1;
                    grant_s       = '0;
                    active_s      = 1'b0;
                    last_grant_s  = owner_r;
                    state_s       = ST_IDLE;
                end else begin
                    cnt_s = cnt_r + TIMEOUT_BITS'(1);
                end
            end
            // req_valid is deliberately ignored here so a stale valid cannot re-accept.
            ST_WAIT: begin
                if (tx_done_tick && last_flag_r) begin
                    grant_s      = '0;
                    active_s     = 1'b0;
                    last_grant_s = owner_r;
                    state_s      = ST_IDLE;
                end else if (tx_done_tick) begin
                    cnt_s   = '0;
                    state_s = ST_SEND;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            default: begin
                grant_s  = '0;
                active_s = 1'b0;
                state_s  = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset drops any accepted-but-unsent byte.
    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            grant_r       <= '0;
            active_r      <= 1'b0;
            req_ready_r   <= '0;
            tx_start_r    <= 1'b0;
            tx_data_r     <= '0;
            timeout_evt_r <= 1'b0;
            last_grant_r  <= LAST_IDX;
            owner_r       <= '0;
            last_flag_r   <= 1'b0;
            cnt_r         <= '0;
        end else begin
            state_r       <= state_s;
            grant_r       <= grant_s;
            active_r      <= active_s;
            req_ready_r   <= req_ready_s;
            tx_start_r    <= tx_start_s;
            tx_data_r     <= tx_data_s;
            timeout_evt_r <= timeout_evt_s;
            last_grant_r  <= last_grant_s;
            owner_r       <= owner_s;
            last_flag_r   <= last_flag_s;
            cnt_r         <= cnt_s;
        end
    end

    assign grant       = grant_r;
    assign active      = active_r;
    assign req_ready   = req_ready_r;
    assign tx_start    = tx_start_r;
    assign tx_data     = tx_data_r;
    assign timeout_evt = timeout_evt_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized message traffic,
// scored against a message-level round-robin model and a simple transmitter model.
module tb_uart_tx_arbiter;

    localparam int NR  = 2;
    localparam int DB  = 8;
    localparam int TMO = 16;

    logic              clk_50MHz = 1'b0;
    logic              reset     = 1'b1;
    logic [NR-1:0]     req_valid = '0;
    logic [NR*DB-1:0]  req_data  = '0;
    logic [NR-1:0]     req_last  = '0;
    logic [NR-1:0]     req_ready;
    logic              tx_start;
    logic [DB-1:0]     tx_data;
    logic              tx_busy;
    logic              tx_done_tick;
    logic [NR-1:0]     grant;
    logic              active;
    logic              timeout_evt;

    logic model_busy = 1'b0, force_busy = 1'b0;
    logic model_done = 1'b0, spur_done  = 1'b0;
    assign tx_busy      = model_busy | force_busy;
    assign tx_done_tick = model_done | spur_done;

    always #10 clk_50MHz = ~clk_50MHz;

    uart_tx_arbiter #(
        .DATA_BITS(DB), .NUM_REQ(NR), .TIMEOUT_CYCLES(TMO), .TIMEOUT_BITS(5)
    ) dut (
        .clk_50MHz(clk_50MHz), .reset(reset),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data),
        .tx_busy(tx_busy), .tx_done_tick(tx_done_tick),
        .grant(grant), .active(active), .timeout_evt(timeout_evt)
    );

    typedef struct packed {
        logic [7:0] req;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    logic [8:0] rq [NR][$];        // requester-side pending {last, data}
    int         msg_len [NR][$];   // model view: message lengths per requester
    logic [7:0] msg_byte [NR][$];
    logic [7:0] msg_buf[$];

    int rr_last = NR - 1;
    int checks = 0, errors = 0;
    int cyc = 0, tx_cnt = 0, done_delay = 10, done_cyc = 0;
    int n_start = 0, n_rdy0 = 0, gap_cnt = 0;
    bit rand_delay = 1'b0, gap_en = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic enqueue_msg(input int r, input bit with_last);
        for (int i = 0; i < msg_buf.size(); i++) begin
            rq[r].push_back({with_last && (i == msg_buf.size() - 1), msg_buf[i]});
            msg_byte[r].push_back(msg_buf[i]);
        end
        msg_len[r].push_back(msg_buf.size());
        msg_buf.delete();
    endtask

    // Whole messages in round-robin order, starting after the last released owner.
    task automatic predict();
        int   pick;
        int   n;
        exp_t e;
        while (1) begin
            pick = -1;
            for (int k = 1; k <= NR; k++) begin
                int idx;
                idx = (rr_last + k) % NR;
                if (pick < 0 && msg_len[idx].size() > 0) pick = idx;
            end
            if (pick < 0) break;
            n = msg_len[pick].pop_front();
            for (int j = 0; j < n; j++) begin
                e.req  = 8'(pick);
                e.data = msg_byte[pick].pop_front();
                exp_q.push_back(e);
            end
            rr_last = pick;
        end
    endtask

    // One clock: sample outputs, score, then update transmitter and requesters.
    task automatic step_cycle();
        exp_t       e;
        logic [8:0] head;
        @(negedge clk_50MHz);
        cyc++;
        check_eq("grant_onehot", 32'($countones(grant) <= 1), 32'd1);
        check_eq("active_vs_grant", 32'(active), 32'(|grant));
        if (tx_start) begin
            n_start++;
            check_eq("start_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_eq("tx_data", 32'(tx_data), 32'(e.data));
                check_eq("owner", 32'(grant), 32'(1) << e.req);
            end
            check_eq("ready_with_start", 32'(req_ready), 32'(grant));
        end else begin
            check_eq("ready_without_start", 32'(req_ready), 32'd0);
        end
        for (int i = 0; i < NR; i++) begin
            if (req_ready[i]) begin
                if (i == 0) n_rdy0++;
                check_eq("pop_nonempty", 32'(rq[i].size() > 0), 32'd1);
                if (rq[i].size() > 0) void'(rq[i].pop_front());
            end
        end
        model_done = 1'b0;
        if (tx_cnt > 0) begin
            tx_cnt--;
            if (tx_cnt == 0) begin
                model_done = 1'b1;
                model_busy = 1'b0;
                done_cyc   = cyc;
            end
        end
        if (tx_start) begin
            model_busy = 1'b1;
            tx_cnt     = rand_delay ? int'($urandom_range(1, 8)) : done_delay;
        end
        if (gap_cnt > 0) gap_cnt--;
        else if (gap_en && grant != '0 && $urandom_range(0, 7) == 0) gap_cnt = int'($urandom_range(1, 5));
        for (int i = 0; i < NR; i++) begin
            if (rq[i].size() > 0) begin
                head = rq[i][0];
                req_valid[i]           = !(grant[i] && gap_cnt > 0);
                req_data[i*DB +: DB]   = head[7:0];
                req_last[i]            = head[8];
            end else begin
                req_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic run_idle(input string tag, input int budget);
        int n;
        n = 0;
        do begin
            step_cycle();
            n++;
        end while ((exp_q.size() > 0 || active || tx_cnt > 0) && n < budget);
        check_eq({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
        check_eq({tag, "_idle"}, 32'(active), 32'd0);
    endtask

    // Asserts reset away from any rising edge so the zeroing must be asynchronous.
    task automatic do_reset();
        @(negedge clk_50MHz);
        #3 reset = 1'b0;
        #1 check_eq("reset_outputs",
                    32'({grant, req_ready, active, tx_start, timeout_evt, tx_data}), 32'd0);
        exp_q.delete();
        for (int i = 0; i < NR; i++) begin
            rq[i].delete();
            msg_len[i].delete();
            msg_byte[i].delete();
        end
        rr_last = NR - 1;
        tx_cnt = 0; model_busy = 1'b0; model_done = 1'b0;
        force_busy = 1'b0; spur_done = 1'b0; gap_cnt = 0;
        req_valid = '0;
        repeat (2) @(negedge clk_50MHz);
        reset = 1'b1;
        step_cycle();
    endtask

    initial begin
        int n;
        do_reset();

        // Single three-byte message, with grant and first-byte latency.
        msg_buf = '{8'h24, 8'h47, 8'h50};
        enqueue_msg(0, 1'b1);
        predict();
        n_start = 0; n_rdy0 = 0;
        step_cycle();
        step_cycle();
        check_eq("t1_grant_latency", 32'(grant), 32'h1);
        step_cycle();
        check_eq("t1_start_latency", 32'(tx_start), 32'd1);
        check_eq("t1_ready_latency", 32'(req_ready), 32'h1);
        run_idle("t1", 2000);
        check_eq("t1_n_start", 32'(n_start), 32'd3);
        check_eq("t1_n_ready", 32'(n_rdy0), 32'd3);
        check_eq("t1_grant_clear", 32'(grant), 32'd0);

        // Simultaneous contention straight after reset.
        do_reset();
        msg_buf = '{8'h41, 8'h42}; enqueue_msg(0, 1'b1);
        msg_buf = '{8'h61, 8'h62}; enqueue_msg(1, 1'b1);
        predict();
        run_idle("t2", 2000);

        // Alternation over four messages.
        msg_buf = '{8'hA0, 8'hA1}; enqueue_msg(0, 1'b1);
        msg_buf = '{8'hA2};        enqueue_msg(0, 1'b1);
        msg_buf = '{8'hB0};        enqueue_msg(1, 1'b1);
        msg_buf = '{8'hB1, 8'hB2}; enqueue_msg(1, 1'b1);
        predict();
        run_idle("t3", 2000);

        // Owner goes silent after a non-last byte; requester 1 waits behind it.
        msg_buf = '{8'h31}; enqueue_msg(0, 1'b0);
        msg_buf = '{8'h55}; enqueue_msg(1, 1'b1);
        predict();
        n = 0;
        do begin
            step_cycle();
            n++;
        end while (!timeout_evt && n < 300);
        check_eq("t4_timeout_seen", 32'(timeout_evt), 32'd1);
        // done is driven one call before the edge that re-enters SEND, hence +1
        check_eq("t4_timeout_delay", 32'(cyc - done_cyc), 32'(TMO + 1));
        check_eq("t4_grant_revoked", 32'(grant), 32'd0);
        step_cycle();
        check_eq("t4_next_grant", 32'(grant), 32'h2);
        check_eq("t4_evt_pulse", 32'(timeout_evt), 32'd0);
        run_idle("t4", 2000);

        // Transmitter held busy, plus a stray done tick while sending.
        force_busy = 1'b1;
        msg_buf = '{8'h77}; enqueue_msg(0, 1'b1);
        predict();
        n_start = 0;
        repeat (6) step_cycle();
        check_eq("t5_grant", 32'(grant), 32'h1);
        spur_done = 1'b1;
        step_cycle();
        spur_done = 1'b0;
        repeat (3) step_cycle();
        check_eq("t5_grant_kept", 32'(grant), 32'h1);
        check_eq("t5_no_start", 32'(n_start), 32'd0);
        force_busy = 1'b0;
        step_cycle();
        check_eq("t5_start_on_release", 32'(tx_start), 32'd1);
        run_idle("t5", 2000);

        // Reset while waiting on the second byte of a message.
        msg_buf = '{8'h24, 8'h47, 8'h50}; enqueue_msg(0, 1'b1);
        predict();
        n = 0;
        do begin
            step_cycle();
            n++;
        end while (!(tx_start && tx_data == 8'h47) && n < 500);
        check_eq("t6_reached_47", 32'(tx_data), 32'h47);
        step_cycle();
        step_cycle();
        do_reset();
        msg_buf = '{8'h61}; enqueue_msg(1, 1'b1);
        msg_buf = '{8'h41}; enqueue_msg(0, 1'b1);
        predict();
        step_cycle();
        step_cycle();
        check_eq("t6_first_after_reset", 32'(grant), 32'h1);
        run_idle("t6", 2000);

        // Randomized traffic with random transmit times and short owner gaps.
        rand_delay = 1'b1;
        gap_en     = 1'b1;
        for (int round = 0; round < 8; round++) begin
            for (int r = 0; r < NR; r++) begin
                int nm;
                nm = int'($urandom_range(0, 3));
                for (int m = 0; m < nm; m++) begin
                    int len;
                    len = int'($urandom_range(1, 4));
                    for (int b = 0; b < len; b++) msg_buf.push_back(8'($urandom_range(0, 255)));
                    enqueue_msg(r, 1'b1);
                end
            end
            predict();
            run_idle("rand", 3000);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
